sram_mem_arbiter: RTL and testbench
===================================

Name: sram_mem_arbiter

Overview:
- Shares one external 16-bit-wide SRAM between the instruction-fetch port (IF stage) and the data port (MEM stage) of the ARM pipeline.
- Sequences each 32-bit word access as two halfword phases with programmable wait states.
- Returns read data and a one-cycle ready pulse to the granted requester.
- Generates the freeze signals that stall the pipeline while an access is outstanding.

Parameters:
- WAIT_CYCLES, 1, extra cycles per halfword phase; phase length = WAIT_CYCLES+1; legal range 1..15.
- ADDR_BASE, 1024, byte offset subtracted from incoming addresses before mapping to SRAM.
- SRAM_AW, 18, SRAM halfword address width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- if_req  input  1  instruction fetch request; held until if_ready
- if_addr  input  32  fetch byte address, word aligned
- if_rdata  output  32  fetched word
- if_ready  output  1  one-cycle pulse, fetch complete
- mem_rd  input  1  data read request; held until mem_ready
- mem_wr  input  1  data write request; held until mem_ready
- mem_addr  input  32  data byte address, word aligned
- mem_wdata  input  32  write data
- mem_rdata  output  32  read data
- mem_ready  output  1  one-cycle pulse, data access complete
- freeze_if  output  1  stall PC and IF/ID register
- freeze_pipe  output  1  stall ID/EXE/MEM registers
- busy  output  1  high whenever the FSM is not IDLE
- sram_addr  output  SRAM_AW  halfword address
- sram_wdata  output  16  halfword write data
- sram_rdata  input  16  halfword read data
- sram_we_n  output  1  active-low write strobe

Behaviour:
- Reset values:
  - FSM in IDLE.
  - if_rdata = 0, mem_rdata = 0.
  - if_ready = 0, mem_ready = 0, busy = 0.
  - sram_addr = 0, sram_wdata = 0, sram_we_n = 1.
- Reset mid-transaction:
  - Transaction is abandoned immediately; all outputs take their reset values.
  - No write completion is guaranteed.
- FSM states and transitions:
  - IDLE: samples requests.
    - Grant order: MEM (mem_rd|mem_wr) first, otherwise IF. MEM has fixed priority.
    - On a grant: latch grantee, operation, word address waddr = (addr-ADDR_BASE)>>2, and write data; go to LO.
    - No request: stay in IDLE.
  - LO: sram_addr = {waddr,0}, sram_wdata = wdata[15:0].
    - Phase counter runs 0..WAIT_CYCLES.
    - Read: sram_rdata latched into lo half at count==WAIT_CYCLES.
    - Write: sram_we_n = 0 for counts 0..WAIT_CYCLES-1, 1 on the last count (data/address hold cycle).
    - Go to HI after count==WAIT_CYCLES.
  - HI: same as LO with sram_addr = {waddr,1}, wdata[31:16], hi half.
    - Go to DONE after count==WAIT_CYCLES.
  - DONE: grantee's ready = 1 for exactly this cycle.
    - Grantee's rdata = {hi,lo}, registered and held until that port's next completion.
    - Writes leave mem_rdata unchanged.
    - Go to IDLE.
- Latency:
  - Request sampled in IDLE at cycle 0; ready at cycle 2*WAIT_CYCLES+3.
  - With WAIT_CYCLES=1 this is cycle 5.
- Handshake rules:
  - A request still high in the IDLE cycle after DONE starts a new transaction.
  - Requesters must change the address on ready.
  - mem_rd and mem_wr together: treated as write.
- Freeze outputs (combinational):
  - freeze_pipe = (mem_rd|mem_wr) & ~mem_ready.
  - freeze_if = freeze_pipe | (if_req & ~if_ready).
- sram_we_n is never low in IDLE or DONE, or on a read.
- Simultaneous IF+MEM request: MEM served first; IF granted in the IDLE cycle after MEM's DONE.
- Address arithmetic:
  - 32-bit subtraction; result truncated to SRAM_AW-1 word bits; wraps silently.
  - addr[1:0] ignored.

Decomposition:
- Shared package mem_ctrl_pkg holds:
  - FSM state encoding (IDLE, LO, HI, DONE).
  - Grantee encoding (GNT_IF, GNT_MEM).
  - Default WAIT_CYCLES and ADDR_BASE constants.
- Sub-module phase_counter: 4-bit counter with clear, enable and terminal-count output, parameterised by WAIT_CYCLES.
- Everything else stays in one module.

Test Plan:
- Reset during HI of a write (WAIT_CYCLES=1) -> next cycle sram_we_n=1, busy=0, both ready=0; rdata outputs stay 0.
- if_req, if_addr=1024, SRAM model holds 0x1111 at half-addr 0 and 0x2222 at half-addr 1 -> if_ready pulses at cycle 5; if_rdata=0x22221111; sram_addr sequence 0,0,1,1.
- mem_wr, mem_addr=1032, mem_wdata=0xDEADBEEF -> SRAM half 4 = 0xBEEF, half 5 = 0xDEAD; sram_we_n low exactly 1 cycle per phase; freeze_pipe high cycles 0-4.
- if_req and mem_rd both raised at cycle 0 -> mem_ready at cycle 5, if_ready at cycle 11; freeze_if high throughout cycles 0-10.
- WAIT_CYCLES=3, mem_rd of a word written earlier -> mem_ready at cycle 9; data matches the written word.
- mem_rd and mem_wr both high -> a write is performed; mem_rdata unchanged from its previous value.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the SRAM arbiter: FSM state encoding, grantee encoding
// and the default timing/address parameters.
package mem_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LO   = 2'd1;
  localparam logic [1:0] ST_HI   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic GNT_IF  = 1'b0;
  localparam logic GNT_MEM = 1'b1;

  localparam int WAIT_CYCLES_DEF = 1;
  localparam int ADDR_BASE_DEF   = 1024;
  localparam int SRAM_AW_DEF     = 18;

endpackage

// File: rtl/sram_mem_arbiter_if.sv
// Pipeline-side bus of the SRAM arbiter: IF fetch port, MEM data port and the
// freeze outputs. The pipeline is the master, the arbiter is the slave.
interface sram_mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;

  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  logic        freeze_if;
  logic        freeze_pipe;

  modport master (
    output if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata,
    input  if_rdata, if_ready, mem_rdata, mem_ready, freeze_if, freeze_pipe
  );

  modport slave (
    input  if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata,
    output if_rdata, if_ready, mem_rdata, mem_ready, freeze_if, freeze_pipe
  );
endinterface

// File: rtl/sram_mem_arbiter_phase_counter.sv
// Halfword phase timer: counts 0..WAIT_CYCLES while enabled and flags the last
// count of the phase.
module phase_counter #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [3:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (en)
      count <= count + 4'd1;
  end

  assign tc = en && (count == 4'(WAIT_CYCLES));

endmodule

// File: rtl/sram_mem_arbiter.sv
// Arbitrates one 16-bit SRAM between the IF fetch port and the MEM data port,
// splitting each 32-bit access into low and high halfword phases.
module sram_mem_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF,
  parameter int ADDR_BASE   = ADDR_BASE_DEF,
  parameter int SRAM_AW     = SRAM_AW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  sram_mem_arbiter_if.slave    bus,
  output logic                 busy,
  output logic [SRAM_AW-1:0]   sram_addr,
  output logic [15:0]          sram_wdata,
  input  logic [15:0]          sram_rdata,
  output logic                 sram_we_n
);

  logic [1:0]         state;
  logic               gnt;
  logic               op_wr;
  logic [SRAM_AW-2:0] waddr;
  logic [31:0]        wdata;
  logic [15:0]        lo_half;
  logic [31:0]        if_rdata_q;
  logic [31:0]        mem_rdata_q;

  logic               mem_req;
  logic               in_phase;
  logic               tc;
  logic [31:0]        req_addr;
  logic [31:0]        offset;

  assign mem_req  = bus.mem_rd | bus.mem_wr;
  assign in_phase = (state == ST_LO) || (state == ST_HI);

  // Byte offset from the SRAM window, wrapping in 32 bits; the shift drops
  // the byte lane and the slice keeps only the word bits the SRAM can hold.
  assign req_addr = mem_req ? bus.mem_addr : bus.if_addr;
  assign offset   = req_addr - 32'(ADDR_BASE);

  phase_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_phase_counter (
    .clk (clk),
    .rst (rst),
    .clr (tc),
    .en  (in_phase),
    .tc  (tc)
  );

  // NOTE: every register, including the data holding registers, is cleared by
  // the async reset so a reset mid-access leaves no stale read data visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      gnt         <= GNT_IF;
      op_wr       <= 1'b0;
      waddr       <= '0;
      wdata       <= '0;
      lo_half     <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mem_req) begin
            gnt   <= GNT_MEM;
            op_wr <= bus.mem_wr;
            waddr <= (SRAM_AW-1)'(offset >> 2);
            wdata <= bus.mem_wdata;
            state <= ST_LO;
          end else if (bus.if_req) begin
            gnt   <= GNT_IF;
            op_wr <= 1'b0;
            waddr <= (SRAM_AW-1)'(offset >> 2);
            state <= ST_LO;
          end
        end
        ST_LO: begin
          if (tc) begin
            if (!op_wr) lo_half <= sram_rdata;
            state <= ST_HI;
          end
        end
        ST_HI: begin
          if (tc) begin
            // The completed word is registered on entry to DONE so it is
            // already valid while ready is high.
            if (!op_wr) begin
              if (gnt == GNT_MEM) mem_rdata_q <= {sram_rdata, lo_half};
              else                if_rdata_q  <= {sram_rdata, lo_half};
            end
            state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: all outputs of this block get a default first, so no path through
  // it can infer a latch.
  always_comb begin
    sram_addr  = '0;
    sram_wdata = '0;
    sram_we_n  = 1'b1;
    if (in_phase) begin
      sram_addr  = {waddr, (state == ST_HI)};
      sram_wdata = (state == ST_HI) ? wdata[31:16] : wdata[15:0];
      // Strobe released on the last count so address and data are held
      // stable across the rising edge of we_n.
      sram_we_n  = ~(op_wr & ~tc);
    end
  end

  assign busy          = (state != ST_IDLE);
  assign bus.if_ready  = (state == ST_DONE) && (gnt == GNT_IF);
  assign bus.mem_ready = (state == ST_DONE) && (gnt == GNT_MEM);
  assign bus.if_rdata  = if_rdata_q;
  assign bus.mem_rdata = mem_rdata_q;

  assign bus.freeze_pipe = mem_req & ~bus.mem_ready;
  assign bus.freeze_if   = bus.freeze_pipe | (bus.if_req & ~bus.if_ready);

endmodule

// File: tb/tb_sram_mem_arbiter.sv
// Self-checking bench for sram_mem_arbiter: two instances (WAIT_CYCLES 1 and 3),
// behavioural SRAM models and a queue of expected read data.
module tb_sram_mem_arbiter;
  import mem_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  logic        sel3;
  logic        if_req, mem_rd, mem_wr;
  logic [31:0] if_addr, mem_addr, mem_wdata;

  sram_mem_arbiter_if bus1();
  sram_mem_arbiter_if bus3();

  assign bus1.if_req    = if_req & ~sel3;
  assign bus1.mem_rd    = mem_rd & ~sel3;
  assign bus1.mem_wr    = mem_wr & ~sel3;
  assign bus1.if_addr   = if_addr;
  assign bus1.mem_addr  = mem_addr;
  assign bus1.mem_wdata = mem_wdata;
  assign bus3.if_req    = if_req & sel3;
  assign bus3.mem_rd    = mem_rd & sel3;
  assign bus3.mem_wr    = mem_wr & sel3;
  assign bus3.if_addr   = if_addr;
  assign bus3.mem_addr  = mem_addr;
  assign bus3.mem_wdata = mem_wdata;

  logic        busy1, busy3, we1, we3;
  logic [17:0] a1, a3;
  logic [15:0] wd1, wd3, rd1, rd3;

  sram_mem_arbiter #(.WAIT_CYCLES(1), .ADDR_BASE(1024), .SRAM_AW(18)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .busy(busy1),
    .sram_addr(a1), .sram_wdata(wd1), .sram_rdata(rd1), .sram_we_n(we1)
  );

  sram_mem_arbiter #(.WAIT_CYCLES(3), .ADDR_BASE(1024), .SRAM_AW(18)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3), .busy(busy3),
    .sram_addr(a3), .sram_wdata(wd3), .sram_rdata(rd3), .sram_we_n(we3)
  );

  // SRAM models: asynchronous read, write on a clock edge while we_n is low
  logic [15:0] mem1 [0:255];
  logic [15:0] mem3 [0:255];
  logic        pre_we;
  logic [7:0]  pre_a;
  logic [15:0] pre_d;

  assign rd1 = mem1[a1[7:0]];
  assign rd3 = mem3[a3[7:0]];

  always @(posedge clk) begin
    if (!we1)        mem1[a1[7:0]] <= wd1;
    else if (pre_we) mem1[pre_a]   <= pre_d;
  end
  always @(posedge clk) begin
    if (!we3) mem3[a3[7:0]] <= wd3;
  end

  // Observation of the selected instance
  logic        o_if_ready, o_mem_ready, o_freeze_if, o_freeze_pipe, o_busy, o_we_n;
  logic [31:0] o_if_rdata, o_mem_rdata;
  logic [17:0] o_sram_addr;
  logic [15:0] o_sram_wdata;
  assign o_if_ready    = sel3 ? bus3.if_ready    : bus1.if_ready;
  assign o_mem_ready   = sel3 ? bus3.mem_ready   : bus1.mem_ready;
  assign o_freeze_if   = sel3 ? bus3.freeze_if   : bus1.freeze_if;
  assign o_freeze_pipe = sel3 ? bus3.freeze_pipe : bus1.freeze_pipe;
  assign o_if_rdata    = sel3 ? bus3.if_rdata    : bus1.if_rdata;
  assign o_mem_rdata   = sel3 ? bus3.mem_rdata   : bus1.mem_rdata;
  assign o_busy        = sel3 ? busy3 : busy1;
  assign o_we_n        = sel3 ? we3   : we1;
  assign o_sram_addr   = sel3 ? a3    : a1;
  assign o_sram_wdata  = sel3 ? wd3   : wd1;

  typedef struct {
    logic        is_if;
    logic [31:0] data;
  } exp_t;
  exp_t sb_q[$];

  int          lat;
  logic [17:0] addr_tr [0:39];
  logic        we_tr   [0:39];
  logic        fp_tr   [0:39];

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    pre_we = 1'b1; pre_a = a; pre_d = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  // Issues one request at cycle 0, traces SRAM pins until ready, then checks
  // latency and the returned data against the scoreboard.
  task automatic run_txn(input logic is_if, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input int exp_lat, input logic [31:0] exp_data,
                         input string name);
    exp_t e;
    logic [31:0] got;
    sb_q.push_back('{is_if, exp_data});
    @(posedge clk); #1;
    if (is_if) begin if_req = 1'b1; if_addr = addr; end
    else begin mem_rd = rd; mem_wr = wr; mem_addr = addr; mem_wdata = wd; end
    lat = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      addr_tr[c] = o_sram_addr;
      we_tr[c]   = o_we_n;
      fp_tr[c]   = o_freeze_pipe;
      if (is_if ? o_if_ready : o_mem_ready) begin lat = c; break; end
    end
    got = is_if ? o_if_rdata : o_mem_rdata;
    e = sb_q.pop_front();
    n_checks++;
    if (lat !== exp_lat) begin
      n_err++; $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    n_checks++;
    if (got !== e.data) begin
      n_err++; $display("FAIL %s rdata: got %h expected %h", name, got, e.data);
    end
    @(posedge clk); #1;
    if_req = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
  endtask

  task automatic check_idle_outputs(input string name);
    n_checks++;
    if ({o_busy, o_we_n, o_if_ready, o_mem_ready} !== 4'b0100) begin
      n_err++; $display("FAIL %s busy/we_n/if_ready/mem_ready: got %b expected 0100",
                        name, {o_busy, o_we_n, o_if_ready, o_mem_ready});
    end
    n_checks++;
    if ({o_if_rdata, o_mem_rdata} !== 64'd0) begin
      n_err++; $display("FAIL %s rdata: got %h/%h expected 0/0", name, o_if_rdata, o_mem_rdata);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    n_checks++;
    if ({o_sram_addr, o_sram_wdata} !== 34'd0) begin
      n_err++; $display("FAIL reset sram_addr/wdata: got %h/%h expected 0/0", o_sram_addr, o_sram_wdata);
    end
    #1 rst = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    @(posedge clk); #1;
    mem_wr = 1'b1; mem_addr = 32'd1088; mem_wdata = 32'hA5A55A5A;
    repeat (4) @(negedge clk);
    n_checks++;
    if (o_we_n !== 1'b0) begin
      n_err++; $display("FAIL midwrite we_n in HI: got %b expected 0", o_we_n);
    end
    #1 rst = 1'b1; mem_wr = 1'b0;
    @(posedge clk); @(negedge clk);
    check_idle_outputs("midwrite_reset");
    #1 rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check_idle_outputs("midwrite_after");
  endtask

  task automatic test_if_read();
    logic [17:0] exp_a [0:3];
    exp_a = '{18'd0, 18'd0, 18'd1, 18'd1};
    preload(8'd0, 16'h1111);
    preload(8'd1, 16'h2222);
    run_txn(1'b1, 1'b0, 1'b0, 32'd1024, 32'd0, 5, 32'h22221111, "if_read");
    for (int c = 1; c <= 4; c++) begin
      n_checks++;
      if (addr_tr[c] !== exp_a[c-1]) begin
        n_err++; $display("FAIL if_read sram_addr cycle %0d: got %0d expected %0d", c, addr_tr[c], exp_a[c-1]);
      end
    end
  endtask

  task automatic test_mem_write();
    int lo_n, hi_n, fp_n;
    run_txn(1'b0, 1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 5, 32'd0, "mem_write");
    n_checks++;
    if (mem1[4] !== 16'hBEEF || mem1[5] !== 16'hDEAD) begin
      n_err++; $display("FAIL mem_write sram halves 4/5: got %h/%h expected beef/dead", mem1[4], mem1[5]);
    end
    lo_n = 0; hi_n = 0; fp_n = 0;
    for (int c = 1; c <= 2; c++) if (we_tr[c] === 1'b0) lo_n++;
    for (int c = 3; c <= 4; c++) if (we_tr[c] === 1'b0) hi_n++;
    for (int c = 0; c <= 4; c++) if (fp_tr[c] === 1'b1) fp_n++;
    n_checks++;
    if (lo_n != 1 || hi_n != 1) begin
      n_err++; $display("FAIL mem_write we_n low cycles lo/hi: got %0d/%0d expected 1/1", lo_n, hi_n);
    end
    n_checks++;
    if (we_tr[0] !== 1'b1 || we_tr[5] !== 1'b1) begin
      n_err++; $display("FAIL mem_write we_n in IDLE/DONE: got %b/%b expected 1/1", we_tr[0], we_tr[5]);
    end
    n_checks++;
    if (fp_n != 5 || fp_tr[5] !== 1'b0) begin
      n_err++; $display("FAIL mem_write freeze_pipe: got %0d high cycles, cycle5=%b expected 5, 0", fp_n, fp_tr[5]);
    end
  endtask

  task automatic test_simultaneous();
    int   mem_lat, if_lat, fi_n;
    logic mem_done;
    logic fi_tr [0:19];
    exp_t e;
    sb_q.push_back('{1'b0, 32'hDEADBEEF});
    sb_q.push_back('{1'b1, 32'h22221111});
    mem_lat = -1; if_lat = -1; fi_n = 0; mem_done = 1'b0;
    for (int c = 0; c < 20; c++) fi_tr[c] = 1'b0;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'd1024; mem_rd = 1'b1; mem_addr = 32'd1032;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      fi_tr[c] = o_freeze_if;
      if (o_mem_ready) begin
        mem_lat = c; mem_done = 1'b1;
        e = sb_q.pop_front();
        n_checks++;
        if (e.is_if !== 1'b0 || o_mem_rdata !== e.data) begin
          n_err++; $display("FAIL simul mem_rdata: got %h expected %h", o_mem_rdata, e.data);
        end
      end
      if (o_if_ready) begin
        if_lat = c;
        e = sb_q.pop_front();
        n_checks++;
        if (e.is_if !== 1'b1 || o_if_rdata !== e.data) begin
          n_err++; $display("FAIL simul if_rdata: got %h expected %h", o_if_rdata, e.data);
        end
        break;
      end
      @(posedge clk); #1;
      if (mem_done) mem_rd = 1'b0;
    end
    @(posedge clk); #1;
    if_req = 1'b0; mem_rd = 1'b0;
    sb_q.delete();
    for (int c = 0; c <= 10; c++) if (fi_tr[c] === 1'b1) fi_n++;
    n_checks++;
    if (mem_lat != 5 || if_lat != 11) begin
      n_err++; $display("FAIL simul ready cycles mem/if: got %0d/%0d expected 5/11", mem_lat, if_lat);
    end
    n_checks++;
    if (fi_n != 11 || fi_tr[11] !== 1'b0) begin
      n_err++; $display("FAIL simul freeze_if: got %0d high cycles, cycle11=%b expected 11, 0", fi_n, fi_tr[11]);
    end
  endtask

  task automatic test_rd_wr_both();
    run_txn(1'b0, 1'b1, 1'b1, 32'd1040, 32'h12345678, 5, 32'hDEADBEEF, "rdwr_write");
    n_checks++;
    if (mem1[8] !== 16'h5678 || mem1[9] !== 16'h1234) begin
      n_err++; $display("FAIL rdwr sram halves 8/9: got %h/%h expected 5678/1234", mem1[8], mem1[9]);
    end
    run_txn(1'b0, 1'b1, 1'b0, 32'd1040, 32'd0, 5, 32'h12345678, "rdwr_readback");
  endtask

  task automatic test_wait3();
    sel3 = 1'b1;
    run_txn(1'b0, 1'b0, 1'b1, 32'd1048, 32'hCAFEF00D, 9, 32'd0, "wait3_write");
    run_txn(1'b0, 1'b1, 1'b0, 32'd1048, 32'd0, 9, 32'hCAFEF00D, "wait3_read");
    sel3 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sel3 = 1'b0; pre_we = 1'b0; pre_a = '0; pre_d = '0;
    if_req = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
    if_addr = '0; mem_addr = '0; mem_wdata = '0;
    test_reset();
    test_reset_mid_write();
    test_if_read();
    test_mem_write();
    test_simultaneous();
    test_rd_wr_both();
    test_wait3();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
